// File: rtl/console_uart_tx.sv
// Memory-mapped console output: bus writes queue bytes in a small FIFO,
// and a single FSM sends them out on tx as 8N1 UART frames.
module console_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic       sel;
    logic [1:0] offset;
    logic       full;
    logic       empty;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_clr;
    logic [7:0] count8;
    logic       unused_bits;

    assign sel      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset   = mem_addr[3:2];
    assign full     = (count == FIFO_FULL);
    assign empty    = (count == '0);
    // Fullness is judged on pre-edge state, so a pop in the same cycle
    // does not rescue a write to a full FIFO.
    assign push_req = sel && mem_we && (offset == 2'd0);
    assign push     = push_req && !full;
    assign pop      = (state == IDLE) && !empty;
    assign ovf_clr  = sel && mem_we && (offset == 2'd1) && mem_wdata[3];
    assign count8   = 8'(count);
    assign tx_busy  = !empty || (state != IDLE);

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_wdata[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push beats a software clear in the same cycle.
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!empty) begin
                        shift <= fifo_mem[rd_ptr];
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Reads are combinational and only drive data for a selected STATUS read.
    always_comb begin
        mem_rdata = '0;
        if (sel && mem_re && (offset == 2'd1)) begin
            mem_rdata[0]    = full;
            mem_rdata[1]    = empty;
            mem_rdata[2]    = (state != IDLE);
            mem_rdata[3]    = overflow;
            mem_rdata[15:8] = count8;
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: bus driver tasks, a tx line decoder feeding a
// byte scoreboard, and cycle-exact checks of frame timing and STATUS.
module tb_console_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB + 1;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        mem_we    = 1'b0;
    logic        mem_re    = 1'b0;
    logic [31:0] mem_addr  = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    int         cyc        = 0;
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = '0;

    console_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: entered and left 1ns after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a;
        mem_re   = 1'b1;
        @(negedge clk);
        d = mem_rdata;
        @(posedge clk);
        #1;
        mem_re = 1'b0;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        mem_addr  = a;
        mem_wdata = wd;
        mem_we    = 1'b1;
        mem_re    = 1'b1;
        @(negedge clk);
        rd = mem_rdata;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        mem_re = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit accept);
        logic [31:0] wd;
        wd       = $urandom();
        wd[7:0]  = b;
        if (accept) exp_q.push_back(b);
        bus_write(BASE, wd);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, tx_busy}, 32'd0);
    endtask

    // Line decoder: samples mid-bit on falling edges, aborts on reset.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_byte[(mon_cnt - 6) / 4] = tx;
            if (mon_cnt == 38) begin
                check("stop_bit", {31'd0, tx}, 32'd1);
                check("rx_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic        exp_tx;
        int          lows;
        int          s0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus_read(BASE + 32'h4, rd);
        check("rst_status", rd, 32'h0000_0002);

        // Unselected and reserved writes must not push.
        bus_write(BASE + 32'h10, 32'hAA);
        bus_write(BASE + 32'h8, 32'hAA);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        @(posedge clk);
        #1;
        check("unsel_idle", lows, 0);
        bus_read(BASE + 32'h10, rd);
        check("read_unsel", rd, 32'd0);
        bus_read(BASE + 32'h8, rd);
        check("read_resv", rd, 32'd0);
        bus_read(BASE, rd);
        check("read_txdata", rd, 32'd0);
        bus_read(BASE + 32'h4, rd);
        check("unsel_status", rd, 32'h0000_0002);

        // Single byte 0x48 with a cycle-exact waveform check.
        b = 8'h48;
        tx_byte(b, 1'b1);
        @(negedge clk);
        check("t0_busy", {31'd0, tx_busy}, 32'd1);
        check("t0_tx", {31'd0, tx}, 32'd1);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 4)       exp_tx = 1'b0;
            else if (k <= 36) exp_tx = b[(k - 5) / 4];
            else              exp_tx = 1'b1;
            check($sformatf("wave_tx_%0d", k), {31'd0, tx}, {31'd0, exp_tx});
            check($sformatf("wave_busy_%0d", k), {31'd0, tx_busy}, {31'd0, k <= 40});
        end
        @(posedge clk);
        #1;

        // Burst "Hello" on consecutive cycles.
        s0 = start_q.size();
        tx_byte(8'h48, 1'b1);
        tx_byte(8'h65, 1'b1);
        tx_byte(8'h6C, 1'b1);
        tx_byte(8'h6C, 1'b1);
        tx_byte(8'h6F, 1'b1);
        bus_read(BASE + 32'h4, rd);
        check("hello_status", rd, 32'h0000_0404);
        wait_idle("hello_drain", 400);
        repeat (3) @(posedge clk);
        #1;
        check("hello_frames", start_q.size() - s0, 5);
        for (int i = 1; i < start_q.size() - s0; i++)
            check($sformatf("hello_gap_%0d", i), start_q[s0 + i] - start_q[s0 + i - 1], FRAME);

        // Overflow: 10 writes, 9 fit because one is popped at T+1.
        for (int i = 0; i < 10; i++)
            tx_byte(8'($urandom_range(0, 255)), i < 9);
        bus_read(BASE + 32'h4, rd);
        check("ovf_status", rd, 32'h0000_080D);
        bus_rw(BASE + 32'h4, 32'h8, rd);
        check("ovf_rw_pre", rd, 32'h0000_080D);
        bus_read(BASE + 32'h4, rd);
        check("ovf_cleared", rd, 32'h0000_0805);
        // Land a write on the edge where the FSM pops the next byte.
        repeat (29) @(posedge clk);
        #1;
        tx_byte(8'hEE, 1'b0);
        bus_read(BASE + 32'h4, rd);
        check("pop_race_status", rd, 32'h0000_070C);
        wait_idle("ovf_drain", 1000);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_q_empty", exp_q.size(), 0);

        // Reset in the middle of the data bits of 0x55.
        tx_byte(8'h55, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        bus_read(BASE + 32'h4, rd);
        check("midrst_status", rd, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("midrst_quiet", lows, 0);

        check("final_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Memory-mapped console output peripheral. The CPU store path writes program output bytes (e.g. "Hello World") into it.
- Bytes are buffered in a small FIFO and serialized as 8N1 UART frames on `tx`.
- It is the transmit/device side of the program-output path. The simulation bench's console monitor is the receiving end.
- Sits on the data-memory bus next to data RAM, selected by address decode.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; must be 16-byte aligned.
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be ≥2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, range 2..128.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_we  in  1  bus write strobe, single cycle
- mem_re  in  1  bus read strobe
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data; combinational, valid in the same cycle as mem_re
- tx  out  1  UART serial out; registered; idle high
- tx_busy  out  1  high when the FIFO is non-empty or a frame is in progress

Behaviour:
- **Clock and reset.** One clock. Reset is synchronous, active-high.
- **Reset values:**
  - tx=1, tx_busy=0, mem_rdata=0.
  - FIFO empty (pointers 0, count 0).
  - overflow flag 0.
  - FSM state IDLE, bit counter 0, baud counter 0.
- **Address decode.** Selected when mem_addr[31:4]==BASE_ADDR[31:4]. Register offset is mem_addr[3:2]. Unselected accesses have no effect, and mem_rdata=0.
- **Offset 0x0 TXDATA (write):**
  - A write pushes mem_wdata[7:0]; bits [31:8] are ignored.
  - If the FIFO is full at the edge, the byte is dropped and overflow is set (sticky).
  - Fullness is judged on pre-edge state: a write to a full FIFO is dropped even if the FSM pops in the same cycle.
  - Reads of 0x0 return 0.
- **Offset 0x4 STATUS (read):**
  - bit0 = full.
  - bit1 = empty.
  - bit2 = FSM not IDLE.
  - bit3 = overflow.
  - [15:8] = FIFO count, zero-extended.
  - All other bits 0.
- **Offset 0x4 STATUS (write):** writing with wdata[3]=1 clears overflow. If a dropped push occurs in the same cycle, set wins.
- Offsets 0x8 and 0xC are reserved: read 0, writes ignored.
- **Simultaneous push and pop (not full):** both occur; the count is unchanged.
- **FSM states and transitions:**
  - IDLE: tx=1. If the FIFO is non-empty at the edge, pop the head into the shift register, drive tx=0 and go to START. Baud counter resets to 0.
  - START: hold for CLKS_PER_BIT cycles, then drive tx=shift[0] and go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, advance the bit index, LSB first. After bit 7 has been held, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Frame timing:**
  - One frame = 10×CLKS_PER_BIT cycles of tx activity.
  - At least one IDLE cycle separates consecutive frames, so back-to-back period = 10×CLKS_PER_BIT+1.
- **Latency:** a write accepted at edge T (FIFO previously empty, FSM IDLE) drives tx low from edge T+1. tx_busy is high from edge T.
- **Counter wrap:** FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- **Reset mid-operation:**
  - The frame is aborted immediately; tx=1 after the reset edge.
  - FIFO contents are discarded.
  - No partial frame resumes after reset deasserts.
- **Bus timing:** no wait states. All accepted writes complete in one cycle. mem_we and mem_re asserted together to the same address: the write takes effect at the edge, and the read returns pre-edge state.

Test Plan:
- CLKS_PER_BIT=4; write 0x48 to TXDATA at edge T.
  - Expected: tx=0 for edges T+1..T+4.
  - Data bits 0,0,0,1,0,0,1,0 (4 cycles each).
  - Stop=1 for 4 cycles.
  - tx_busy falls 40 cycles after T+1.
- Burst-write "Hello" (0x48 0x65 0x6C 0x6C 0x6F) on 5 consecutive cycles.
  - Expected: a bench UART monitor decodes exactly "Hello".
  - Frame starts are spaced 41 cycles apart.
  - STATUS count reads 4 on the cycle after the burst.
- FIFO_DEPTH=8; write 10 bytes on consecutive cycles while the first frame starts.
  - Expected: 9 accepted (1 popped at T+1, so 8 remain), the 10th dropped.
  - STATUS[3]=1 and STATUS[0]=1.
  - Write STATUS with 0x8: overflow reads 0 next cycle.
- Assert rst for 1 cycle midway through the DATA phase of byte 0x55.
  - Expected: tx=1 on the next cycle, STATUS reads 0x0000_0002, no further activity.
- Write 0xAA to BASE_ADDR+0x10 and to BASE_ADDR+0x8.
  - Expected: no push, tx stays 1, and reads at both addresses return 0.
- Write to a full FIFO in the same cycle the FSM pops.
  - Expected: the byte is dropped, overflow is set, count = FIFO_DEPTH−1.
